// File: rtl/rc522_reqa_seq.sv
`default_nettype none
// ============================================================================
// Module   : rc522_reqa_seq
// Purpose  : Runs one ISO14443A REQA exchange on the RC522 register-access
//            interface per start pulse. It issues the fixed write/poll/read
//            sequence, evaluates IRQ, error and FIFO status, and returns the
//            ATQA together with a status code.
// Ports    : clk, rst (sync active-high)
//            start -> seq_busy, done, status[2:0], atqa[15:0], card_present
//            req_read, req_write, addr[7:0], wr_data[7:0] -> register i/f
//            rd_data[7:0], data_valid, busy <- register i/f
// Status   : 0 OK, 1 NO_CARD, 2 POLL_TIMEOUT, 3 PROTO_ERR, 4 LEN_ERR,
//            5 BUS_TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module rc522_reqa_seq #(
  parameter int POLL_MAX    = 64,
  parameter int TXN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        seq_busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [15:0] atqa,
  output logic        card_present,
  output logic        req_read,
  output logic        req_write,
  output logic [7:0]  addr,
  output logic [7:0]  wr_data,
  input  logic [7:0]  rd_data,
  input  logic        data_valid,
  input  logic        busy
);

  localparam int WDW = $clog2(TXN_TIMEOUT + 1);

  localparam logic [2:0] c_st_ok       = 3'd0;
  localparam logic [2:0] c_st_no_card  = 3'd1;
  localparam logic [2:0] c_st_poll_to  = 3'd2;
  localparam logic [2:0] c_st_proto    = 3'd3;
  localparam logic [2:0] c_st_len      = 3'd4;
  localparam logic [2:0] c_st_bus_to   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_EVAL      = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t           r_state;
  logic [3:0]       r_step;
  logic             r_cleanup;     // current transaction is the cleanup write
  logic [7:0]       r_poll_cnt;
  logic [WDW-1:0]   r_wdog;
  logic [7:0]       r_rd;
  logic [7:0]       r_atqa_lo;
  logic [7:0]       r_atqa_hi;
  logic [2:0]       r_status_pend; // result reported at the next FINISH

  logic             w_rd;
  logic [7:0]       w_addr;
  logic [7:0]       w_data;
  logic [7:0]       w_poll_next;
  logic             w_wdog_trip;

  // Transaction table: the cleanup write overrides the step table.
  always_comb begin
    w_rd   = 1'b0;
    w_addr = 8'h00;
    w_data = 8'h00;
    if (r_cleanup) begin
      w_addr = 8'h0D;
      w_data = 8'h00;
    end else begin
      case (r_step)
        4'd0:    begin w_addr = 8'h01; w_data = 8'h00; end
        4'd1:    begin w_addr = 8'h04; w_data = 8'h7F; end
        4'd2:    begin w_addr = 8'h0A; w_data = 8'h80; end
        4'd3:    begin w_addr = 8'h0D; w_data = 8'h07; end
        4'd4:    begin w_addr = 8'h09; w_data = 8'h26; end
        4'd5:    begin w_addr = 8'h01; w_data = 8'h0C; end
        4'd6:    begin w_addr = 8'h0D; w_data = 8'h87; end
        4'd7:    begin w_rd = 1'b1; w_addr = 8'h04; end
        4'd8:    begin w_rd = 1'b1; w_addr = 8'h06; end
        4'd9:    begin w_rd = 1'b1; w_addr = 8'h0A; end
        4'd10:   begin w_rd = 1'b1; w_addr = 8'h09; end
        4'd11:   begin w_rd = 1'b1; w_addr = 8'h09; end
        default: begin w_rd = 1'b0; w_addr = 8'h00; end
      endcase
    end
  end

  assign w_poll_next = r_poll_cnt + 8'd1;
  assign w_wdog_trip = (r_wdog == WDW'(TXN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_step        <= 4'd0;
      r_cleanup     <= 1'b0;
      r_poll_cnt    <= 8'd0;
      r_wdog        <= '0;
      r_rd          <= 8'd0;
      r_atqa_lo     <= 8'd0;
      r_atqa_hi     <= 8'd0;
      r_status_pend <= c_st_ok;
      seq_busy      <= 1'b0;
      done          <= 1'b0;
      status        <= 3'd0;
      atqa          <= 16'd0;
      card_present  <= 1'b0;
      req_read      <= 1'b0;
      req_write     <= 1'b0;
      addr          <= 8'd0;
      wr_data       <= 8'd0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      req_read  <= 1'b0;
      req_write <= 1'b0;
      done      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            seq_busy      <= 1'b1;
            r_step        <= 4'd0;
            r_poll_cnt    <= 8'd0;
            r_cleanup     <= 1'b0;
            r_status_pend <= c_st_ok;
            r_atqa_lo     <= 8'd0;
            r_atqa_hi     <= 8'd0;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // A busy interface holds the request back until it is free.
          if (!busy) begin
            addr      <= w_addr;
            wr_data   <= w_data;
            req_read  <= w_rd;
            req_write <= ~w_rd;
            r_wdog    <= '0;
            r_state   <= S_WAIT_RISE;
          end
        end

        S_WAIT_RISE: begin
          if (w_wdog_trip) begin
            r_status_pend <= c_st_bus_to;
            r_state       <= S_FINISH;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (busy) r_state <= S_WAIT_FALL;
          end
        end

        S_WAIT_FALL: begin
          if (w_rd && data_valid) r_rd <= rd_data;
          if (w_wdog_trip) begin
            r_status_pend <= c_st_bus_to;
            r_state       <= S_FINISH;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (!busy) r_state <= S_EVAL;
          end
        end

        S_EVAL: begin
          if (r_cleanup) begin
            r_state <= S_FINISH;
          end else begin
            r_state <= S_ISSUE;
            case (r_step)
              4'd7: begin
                r_poll_cnt <= w_poll_next;
                if (r_rd[5]) begin
                  r_step <= 4'd8;
                end else if (r_rd[0]) begin
                  r_status_pend <= c_st_no_card;
                  r_cleanup     <= 1'b1;
                end else if (w_poll_next == 8'(POLL_MAX)) begin
                  r_status_pend <= c_st_poll_to;
                  r_cleanup     <= 1'b1;
                end
              end
              4'd8: begin
                if ((r_rd & 8'h13) != 8'h00) begin
                  r_status_pend <= c_st_proto;
                  r_cleanup     <= 1'b1;
                end else begin
                  r_step <= 4'd9;
                end
              end
              4'd9: begin
                if (r_rd != 8'h02) begin
                  r_status_pend <= c_st_len;
                  r_cleanup     <= 1'b1;
                end else begin
                  r_step <= 4'd10;
                end
              end
              4'd10: begin
                r_atqa_lo <= r_rd;
                r_step    <= 4'd11;
              end
              4'd11: begin
                r_atqa_hi     <= r_rd;
                r_status_pend <= c_st_ok;
                r_cleanup     <= 1'b1;
              end
              default: begin
                // Steps 0..6 are plain writes with nothing to evaluate.
                r_step <= r_step + 4'd1;
              end
            endcase
          end
        end

        S_FINISH: begin
          done         <= 1'b1;
          seq_busy     <= 1'b0;
          status       <= r_status_pend;
          card_present <= (r_status_pend == c_st_ok);
          atqa         <= (r_status_pend == c_st_ok) ? {r_atqa_hi, r_atqa_lo} : 16'd0;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc522_reqa_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc522_reqa_seq
// Purpose  : Self-checking bench for rc522_reqa_seq. A register-interface
//            responder answers each request; a transaction-list model built
//            from the scenario predicts every request and the final result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc522_reqa_seq;

  localparam int POLL_MAX    = 4;
  localparam int TXN_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seq_busy;
  logic        done;
  logic [2:0]  status;
  logic [15:0] atqa;
  logic        card_present;
  logic        req_read;
  logic        req_write;
  logic [7:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        data_valid;
  logic        busy;

  rc522_reqa_seq #(.POLL_MAX(POLL_MAX), .TXN_TIMEOUT(TXN_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_busy(seq_busy), .done(done),
    .status(status), .atqa(atqa), .card_present(card_present),
    .req_read(req_read), .req_write(req_write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scenario description shared by responder and model.
  logic [7:0] scn_irq[$];
  logic [7:0] scn_err, scn_lvl, scn_f0, scn_f1;
  int         scn_hang;  // 1-based write number that never gets busy; 0 = none

  // Expected transaction list and result.
  typedef struct {
    bit         rd;
    logic [7:0] a;
    logic [7:0] d;
  } txn_t;
  txn_t       exp_q[$];
  logic [2:0] exp_status;
  logic [15:0] exp_atqa;

  logic [7:0] wa [0:6] = '{8'h01, 8'h04, 8'h0A, 8'h0D, 8'h09, 8'h01, 8'h0D};
  logic [7:0] wd [0:6] = '{8'h00, 8'h7F, 8'h80, 8'h07, 8'h26, 8'h0C, 8'h87};

  task automatic push(input bit rd, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.rd = rd; t.a = a; t.d = d;
    exp_q.push_back(t);
  endtask

  // What the register interface must see for this scenario, from the rules.
  task automatic build_model();
    logic [7:0] v;
    bit rx;
    int st;
    exp_q.delete();
    for (int k = 0; k < 7; k++) push(1'b0, wa[k], wd[k]);
    if (scn_hang != 0) begin
      while (exp_q.size() > scn_hang) void'(exp_q.pop_back());
      exp_status = 3'd5;
      exp_atqa   = 16'd0;
      return;
    end
    rx = 0; st = 0;
    for (int i = 0; i < POLL_MAX; i++) begin
      push(1'b1, 8'h04, 8'h00);
      v = scn_irq[(i < scn_irq.size()) ? i : scn_irq.size() - 1];
      if (v[5]) begin rx = 1; break; end
      if (v[0]) begin st = 1; break; end
      if (i == POLL_MAX - 1) st = 2;
    end
    if (rx) begin
      push(1'b1, 8'h06, 8'h00);
      if ((scn_err & 8'h13) != 0) st = 3;
      else begin
        push(1'b1, 8'h0A, 8'h00);
        if (scn_lvl != 8'h02) st = 4;
        else begin
          push(1'b1, 8'h09, 8'h00);
          push(1'b1, 8'h09, 8'h00);
          st = 0;
        end
      end
    end
    push(1'b0, 8'h0D, 8'h00);
    exp_status = 3'(st);
    exp_atqa   = (st == 0) ? {scn_f1, scn_f0} : 16'd0;
  endtask

  // Register-interface responder.
  int  wcount, poll_idx, fifo_idx;
  initial begin
    bit         is_rd;
    logic [7:0] a;
    busy = 1'b0; data_valid = 1'b0; rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (req_read || req_write) begin
        is_rd = req_read;
        a     = addr;
        if (!is_rd) wcount++;
        if (!(!is_rd && scn_hang != 0 && wcount == scn_hang)) begin
          busy = 1'b1;
          @(negedge clk);
          @(negedge clk);
          if (is_rd) begin
            case (a)
              8'h04: begin
                rd_data = scn_irq[(poll_idx < scn_irq.size()) ? poll_idx : scn_irq.size() - 1];
                poll_idx++;
              end
              8'h06:   rd_data = scn_err;
              8'h0A:   rd_data = scn_lvl;
              8'h09: begin
                rd_data = (fifo_idx == 0) ? scn_f0 : scn_f1;
                fifo_idx++;
              end
              default: rd_data = 8'hEE;
            endcase
            data_valid = 1'b1;
          end
          @(negedge clk);
          busy = 1'b0;
          data_valid = 1'b0;
          rd_data = 8'h00;
        end
      end
    end
  end

  // Compare process: every request and every done against the model.
  bit mon_en = 1'b0;
  int done_cnt = 0;
  int last_req_cyc = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (req_read || req_write) begin
        last_req_cyc = cyc;
        if (req_read && req_write) chk("req_exclusive", 32'(req_read & req_write), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_req_addr", {24'd0, addr}, 32'hFFFF);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("req_is_read", 32'(req_read), 32'(t.rd));
          chk("req_addr", {24'd0, addr}, {24'd0, t.a});
          if (!t.rd) chk("req_wr_data", {24'd0, wr_data}, {24'd0, t.d});
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_status", {29'd0, status}, {29'd0, exp_status});
        chk("done_atqa", {16'd0, atqa}, {16'd0, exp_atqa});
        chk("done_card_present", 32'(card_present), 32'(exp_status == 3'd0));
        if (scn_hang != 0) chk("hang_done_latency_le33", 32'((cyc - last_req_cyc) <= 33), 1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs_zero"},
        {seq_busy, done, status, atqa, card_present, req_read, req_write, addr, wr_data} == '0 ? 1 : 0, 1);
  endtask

  task automatic run_scn(input string tag, input bit extra_starts);
    bit got;
    build_model();
    wcount = 0; poll_idx = 0; fifo_idx = 0; done_cnt = 0;
    mon_en = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = (extra_starts && (i == 5 || i == 20 || i == 40)) ? 1'b1 : 1'b0;
      if (done) begin got = 1; break; end
    end
    start = 1'b0;
    if (!got) chk({tag, "_done_timeout"}, 0, 1);
    repeat (12) @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_cnt), 1);
    chk({tag, "_leftover_txns"}, 32'(exp_q.size()), 0);
    chk({tag, "_seq_busy_idle"}, 32'(seq_busy), 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0;
    scn_err = 0; scn_lvl = 0; scn_f0 = 0; scn_f1 = 0; scn_hang = 0;
    scn_irq = '{8'h00};
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Card present, with stray start pulses during the run.
    scn_irq = '{8'h00, 8'h00, 8'h20}; scn_err = 8'h00; scn_lvl = 8'h02;
    scn_f0 = 8'h04; scn_f1 = 8'h00; scn_hang = 0;
    build_model();
    chk("model_card_len", 32'(exp_q.size()), 15);
    run_scn("card", 1'b1);
    chk("card_status_lit", {29'd0, status}, 0);
    chk("card_atqa_lit", {16'd0, atqa}, 32'h0004);
    chk("card_present_lit", 32'(card_present), 1);

    // No card.
    scn_irq = '{8'h01};
    run_scn("nocard", 1'b0);
    chk("nocard_status_lit", {29'd0, status}, 1);
    chk("nocard_atqa_lit", {16'd0, atqa}, 0);

    // Poll exhaustion.
    scn_irq = '{8'h00};
    build_model();
    chk("model_poll_len", 32'(exp_q.size()), 12);
    run_scn("polltmo", 1'b0);
    chk("polltmo_status_lit", {29'd0, status}, 2);

    // Protocol error.
    scn_irq = '{8'h20}; scn_err = 8'h02; scn_lvl = 8'h02;
    run_scn("protoerr", 1'b0);
    chk("protoerr_status_lit", {29'd0, status}, 3);

    // Length error.
    scn_err = 8'h00; scn_lvl = 8'h01;
    run_scn("lenerr", 1'b0);
    chk("lenerr_status_lit", {29'd0, status}, 4);

    // Bus hang on the step-3 write.
    scn_lvl = 8'h02; scn_hang = 4;
    run_scn("bushang", 1'b0);
    chk("bushang_status_lit", {29'd0, status}, 5);
    chk("bushang_atqa_lit", {16'd0, atqa}, 0);
    scn_hang = 0;

    // Reset in the middle of polling.
    scn_irq = '{8'h00};
    wcount = 0; poll_idx = 0; fifo_idx = 0;
    mon_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_read && addr == 8'h04) begin seen = 1; break; end
    end
    if (!seen) chk("midpoll_reached", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midpoll_reset");
    rst = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    // Recovery after reset.
    scn_irq = '{8'h20}; scn_err = 8'h00; scn_lvl = 8'h02; scn_f0 = 8'h44; scn_f1 = 8'h03;
    run_scn("recover", 1'b0);
    chk("recover_atqa_lit", {16'd0, atqa}, 32'h0344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required_below=200000", $time);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/rc522_reqa_seq.md
Name: rc522_reqa_seq

Overview:
- Sequencer that drives the RC522 register-access interface (req_read/req_write/addr/wr_data/rd_data/data_valid/busy) to run one ISO14443A REQA exchange per start pulse.
- Issues the fixed write/poll/read sequence, evaluates the IRQ, error and FIFO status, and returns the 16-bit ATQA with a status code.
- Sits between the card-detect FSM and the register interface; it is the only master of that interface while running.

Parameters:
- POLL_MAX, 64: max ComIrqReg reads before status POLL_TIMEOUT (valid range 1..255).
- TXN_TIMEOUT, 4096: max cycles for one register transaction before status BUS_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin REQA sequence (accepted only in IDLE)
- seq_busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at sequence end
- status  out  3  0 OK, 1 NO_CARD, 2 POLL_TIMEOUT, 3 PROTO_ERR, 4 LEN_ERR, 5 BUS_TIMEOUT; held until next done
- atqa  out  16  ATQA {second byte, first byte}; valid when status==OK
- card_present  out  1  status==OK at last done
- req_read  out  1  one-cycle read request to the register interface
- req_write  out  1  one-cycle write request
- addr  out  8  register address
- wr_data  out  8  write data
- rd_data  in  8  read data, sampled only when data_valid=1
- data_valid  in  1  read result strobe
- busy  in  1  register interface busy

Behaviour:
- Reset: all outputs 0, FSM to IDLE, step=0, poll_cnt=0. Reset in any state (including mid-transaction) drops req_* the following edge. The register interface is not aborted by this block.
- Transaction handshake:
  - ISSUE: if busy==0, drive addr/wr_data and pulse exactly one of req_read/req_write for one cycle, then go to WAIT_RISE.
  - WAIT_RISE: wait for busy=1, then go to WAIT_FALL.
  - WAIT_FALL: wait for busy=0, then go to EVAL.
  - On reads, latch rd_data on any cycle with data_valid=1 during WAIT_FALL.
  - addr/wr_data are held stable from ISSUE until busy falls.
- Watchdog: cycle counter cleared on ISSUE. Reaching TXN_TIMEOUT in WAIT_RISE or WAIT_FALL gives status=5, goes directly to FINISH (no cleanup), atqa=0.
- Step sequence (W=write, R=read; addr, data):
  - 0 W 0x01,0x00 (CommandReg Idle)
  - 1 W 0x04,0x7F (clear ComIrq)
  - 2 W 0x0A,0x80 (flush FIFO)
  - 3 W 0x0D,0x07 (7-bit frame)
  - 4 W 0x09,0x26 (REQA)
  - 5 W 0x01,0x0C (Transceive)
  - 6 W 0x0D,0x87 (StartSend)
  - 7 R 0x04 poll
  - 8 R 0x06 ErrorReg
  - 9 R 0x0A FIFOLevel
  - 10 R 0x09 -> atqa[7:0]
  - 11 R 0x09 -> atqa[15:8]
- EVAL at step 7 (poll): poll_cnt increments on every read. Priority:
  - bit5 RxIRq -> step 8.
  - else bit0 TimerIRq -> status=1.
  - else poll_cnt==POLL_MAX -> status=2.
  - else reissue step 7.
- EVAL at steps 8-9:
  - ErrorReg & 0x13 != 0 -> status=3.
  - FIFOLevel != 2 -> status=4.
- Any status set in EVAL goes to CLEANUP. After step 11, status=0 and go to CLEANUP.
- CLEANUP: one transaction W 0x0D,0x00 (a watchdog trip here overrides status to 5), then FINISH.
- FINISH: done=1 for one cycle; status, atqa and card_present update on that same edge; go to IDLE.
- atqa is forced to 0 for every non-OK status.
- start while seq_busy=1 is ignored. start coincident with done (FINISH cycle) is ignored. start in IDLE sets seq_busy on the next edge.
- data_valid outside WAIT_FALL is ignored. busy already high in ISSUE: hold the request until busy==0.

Test Plan:
- Card present: model returns ComIrq 0x00,0x00,0x20; ErrorReg 0x00; FIFOLevel 0x02; FIFO 0x04,0x00 -> writes in step order with exact addr/data, done once, status=0, atqa=0x0004, card_present=1, final write 0x0D/0x00.
- No card: ComIrq 0x01 on first poll -> no reads of 0x06/0x0A/0x09, cleanup write, status=1, atqa=0.
- Poll exhaustion (POLL_MAX=4): ComIrq always 0x00 -> exactly 4 reads of 0x04, status=2.
- Errors: ErrorReg 0x02 -> status=3. Separate run with FIFOLevel 0x01 -> status=4, no 0x09 reads.
- Bus hang (TXN_TIMEOUT=32): busy never rises after step 3 request -> done at most 33 cycles after the request, status=5, no cleanup write.
- Reset mid-poll and start while running: rst at step 7 -> all outputs 0 next cycle; start pulses during a run produce no second done.
